// File: rtl/handshake_serializer.sv
// Wide-to-narrow serializer: IN_W-bit words in over a ready/ack handshake,
// OUT_W-bit beats out over valid/ack, with a current+next word buffer.
module handshake_serializer #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ack,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ack,
    output logic [1:0]       occupancy
);
    localparam int BEATS = IN_W / OUT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (BEATS < 2 || (IN_W % OUT_W) != 0) begin : g_bad_param
        $error("handshake_serializer: IN_W must be a multiple of OUT_W with at least 2 beats");
    end

    typedef logic [BEATS-1:0][OUT_W-1:0] word_t;

    word_t         cur_q, cur_d;
    word_t         nxt_q, nxt_d;
    logic          cur_v_q, cur_v_d;
    logic          nxt_v_q, nxt_v_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ack_q, in_ack_d;

    logic          take, last_beat, fin, capture, to_cur;
    logic [CW-1:0] sel;

    always_comb begin
        take      = cur_v_q & out_ack;
        last_beat = (cnt_q == CW'(BEATS - 1));
        fin       = take & last_beat;
        // The ack cycle masks in_ready so a held level is not taken twice.
        capture   = in_ready & ~nxt_v_q & ~in_ack_q;
        to_cur    = capture & (~cur_v_q | fin);

        cur_d    = cur_q;
        nxt_d    = nxt_q;
        cur_v_d  = cur_v_q;
        nxt_v_d  = nxt_v_q;
        cnt_d    = cnt_q;
        in_ack_d = capture;

        if (take) cnt_d = fin ? '0 : cnt_q + CW'(1);

        if (fin) begin
            if (nxt_v_q) begin
                cur_d   = nxt_q;
                nxt_v_d = 1'b0;
            end else begin
                cur_v_d = capture;
            end
        end

        // Finishing word and new arrival on the same edge go straight to cur.
        if (to_cur) begin
            cur_d   = in_data;
            cur_v_d = 1'b1;
        end else if (capture) begin
            nxt_d   = in_data;
            nxt_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q    <= '0;
            nxt_q    <= '0;
            cur_v_q  <= 1'b0;
            nxt_v_q  <= 1'b0;
            cnt_q    <= '0;
            in_ack_q <= 1'b0;
        end else begin
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            cur_v_q  <= cur_v_d;
            nxt_v_q  <= nxt_v_d;
            cnt_q    <= cnt_d;
            in_ack_q <= in_ack_d;
        end
    end

    always_comb begin
        sel       = MSB_FIRST ? (CW'(BEATS - 1) - cnt_q) : cnt_q;
        in_ack    = in_ack_q;
        out_valid = cur_v_q;
        out_data  = cur_v_q ? cur_q[sel] : '0;
        out_last  = cur_v_q & last_beat;
        occupancy = 2'(cur_v_q) + 2'(nxt_v_q);
    end

    assert property (@(posedge clk) disable iff (!rst_n) (!nxt_v_q || cur_v_q));

endmodule

// File: doc/handshake_serializer.md
# handshake_serializer

Parametrised wide-to-narrow handshake serializer, successor to the fixed 64→16 device-B controller/datapath pair. It accepts IN_W-bit words from an upstream producer over a ready/ack handshake and emits them as IN_W/OUT_W narrow beats over a per-beat valid/ack handshake to the downstream consumer. A two-entry word buffer (current plus next) lets the next word load while the current one drains, which sustains one beat per cycle. Beat order is selectable at elaboration time.

## Interface
- IN_W, 64, input word width; must be an exact multiple of OUT_W.
- OUT_W, 16, output beat width.
- MSB_FIRST, 1, 1: beat 0 = in_data[IN_W-1 -: OUT_W]; 0: beat 0 = in_data[OUT_W-1:0].
- Derived: BEATS = IN_W/OUT_W (elaboration error if BEATS<2 or IN_W%OUT_W≠0); CW = $clog2(BEATS).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_ready  in  1  upstream word valid (level).
- in_data  in  IN_W  upstream word, stable while in_ready high.
- in_ack  out  1  one-cycle pulse: word captured on the previous edge.
- out_valid  out  1  current beat valid.
- out_data  out  OUT_W  current beat.
- out_last  out  1  current beat is beat BEATS-1 of its word.
- out_ack  in  1  downstream takes the beat this cycle (counts only when out_valid=1).
- occupancy  out  2  words held (0, 1, 2).

## Operation
- State: cur register + cur_v flag, nxt register + nxt_v flag, beat counter cnt[CW-1:0], in_ack register.
- take = out_valid & out_ack; fin = take & (cnt==BEATS-1).
- capture = in_ready & ~nxt_v & ~in_ack (in_ready is ignored during the in_ack cycle).
- On capture, the destination is cur when (~cur_v | fin); otherwise it is nxt. in_ack<=capture.
- On take & ~fin: cnt<=cnt+1.
- On fin: cnt<=0. If nxt_v, cur<=nxt and cur_v stays 1, nxt_v<=0. Otherwise cur_v<=capture.
- Simultaneous fin and capture with nxt_v=0: the new word goes straight into cur, so there is no bubble.
- out_valid=cur_v. out_last=cur_v&(cnt==BEATS-1). occupancy=cur_v+nxt_v.
- out_data = beat cnt of cur in MSB_FIRST order. Drive 0 when ~cur_v.
- Invariant: nxt_v implies cur_v. Violation is an assertion failure.
- Upstream rule: the producer deasserts in_ready or changes in_data in the cycle after in_ack. Holding in_ready with a new word gives one capture every 2 cycles.
- Downstream: out_data/out_last are stable while out_valid & ~out_ack.

## Timing
- Reset (rst_n=0, async): cur_v=nxt_v=0, cnt=0, cur=nxt=0. Outputs in_ack=0, out_valid=0, out_data=0, out_last=0, occupancy=0.
- Reset mid-word discards all held words and partial beats. The first capture after release is possible on the first rising edge with rst_n=1.
- Latency: in_ready at edge k (empty block) → out_valid, beat 0 at cycle k+1, and in_ack at cycle k+1.
- Throughput: 1 beat/cycle while out_ack is held high and upstream keeps the buffer fed.
- A word is BEATS cycles minimum. The upstream 2-cycle handshake is hidden for BEATS≥2.
- out_ack while out_valid=0 is ignored and has no state effect.
- Full (occupancy=2): capture is blocked, in_ack stays 0, and in_ready is held by the producer.

## Test plan
- Single word, defaults: in_data=64'h1111_2222_3333_4444, out_ack=1. Expected: in_ack pulse at cycle 1; beats 1111, 2222, 3333, 4444 on cycles 1-4; out_last only with 4444; occupancy returns to 0 on cycle 5.
- MSB_FIRST=0, same word. Expected beat order 4444, 3333, 2222, 1111.
- Back-to-back streaming: three words with in_ready held, out_ack=1. Expected: 12 consecutive beats with no out_valid gap; occupancy peaks at 2; 3 in_ack pulses.
- Downstream stall: out_ack=0 for 5 cycles at beat 2. Expected: out_data stays 3333 and cnt is frozen; a second word captures into nxt; a third is blocked with in_ack=0 until the first word's fin.
- Reset mid-word: assert rst_n=0 after beat 1 with occupancy=2. Expected: all outputs 0 immediately (async). After release, the next word starts at beat 0 with no stale data.
- IN_W=48, OUT_W=8 (BEATS=6, CW=3). Expected: 6 beats, out_last on the 6th, cnt wraps 5→0.
